multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I datapath. Fetches and decodes each instruction, then drives the ALU operation select, operand-2 select, immediate format, register-file and memory strobes, and PC update. It consumes the ALU's EQ flag to resolve BEQ/BNE. It sits between the instruction/data memory handshakes and the datapath, and is the producer end of the ALU control interface.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter (wraps modulo 2^CNT_WIDTH)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
instr  in  32  instruction word from instruction memory, valid when imem_ack=1
imem_req  out  1  instruction fetch request
imem_ack  in  1  fetch complete; instr valid this cycle
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write enable, qualified by dmem_req
dmem_ack  in  1  data access complete
EQ  in  1  ALU operand equality flag
ALUctrl  out  4  ALU op: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1111 PASS op2
ALUsrc  out  1  1 = immediate as op2, 0 = register
ImmSrc  out  3  000 I, 001 S, 010 B, 011 U, 100 J
IRwrite  out  1  load instruction register
RegWrite  out  1  register file write strobe
ResultSrc  out  2  00 ALUout, 01 mem read data, 10 PC+4
PCwrite  out  1  PC update strobe
PCsrc  out  1  0 = PC+4, 1 = PC+imm
illegal  out  1  sticky illegal-instruction trap
retired  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset (async, rst_n=0): state FETCH; every output 0; retired=0; internal decode registers cleared. Reset mid-instruction aborts immediately; no strobe is issued after release until a new fetch completes.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: imem_req=1 until imem_ack. An ack in the first request cycle is accepted. On ack: IRwrite=1 for that cycle, latch instr, go to DECODE.
- DECODE: 1 cycle. Registers opcode/funct3/funct7 and decoded class.
  - Illegal instruction -> TRAP.
  - Legal instruction -> EXEC.
- Illegal conditions:
  - Opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 1101111}.
  - LW/SW with funct3≠010.
  - Branch funct3 ∉ {000, 001}.
  - R-type funct7 ∉ {0000000, 0100000}, or 0100000 with funct3 ∉ {000, 101}.
  - I-type funct3=001 with funct7≠0, or funct3=101 with funct7 ∉ {0000000, 0100000}.
- ALUctrl/ALUsrc/ImmSrc are held constant from EXEC through the instruction's last state.
- R-type decode (ALUsrc=0):
  - funct3 000: ADD, or SUB if instr[30].
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101: SRL, or SRA if instr[30].
  - 110 OR, 111 AND.
- I-ALU decode (ALUsrc=1, ImmSrc I): same mapping, except 000 is always ADD; instr[30] selects SRA only for 101.
- LW: ADD, ALUsrc=1, ImmSrc I. SW: ADD, ALUsrc=1, ImmSrc S.
- Branch: SUB, ALUsrc=0, ImmSrc B.
- LUI: PASS, ALUsrc=1, ImmSrc U.
- JAL: ADD, ImmSrc J.
- EXEC (1 cycle) transitions:
  - R/I/LUI/JAL -> WB.
  - LW/SW -> MEM.
  - Branch: sample EQ. taken = (BEQ & EQ) | (BNE & ~EQ). Assert PCwrite=1, PCsrc=taken, retired+=1; go to FETCH.
- MEM: dmem_req=1 (dmem_we=1 for SW) held until dmem_ack.
  - SW on ack: PCwrite=1, PCsrc=0, retired+=1 -> FETCH.
  - LW on ack -> WB.
- WB (1 cycle): RegWrite=1, PCwrite=1, retired+=1 -> FETCH.
  - ResultSrc: 01 for LW, 10 for JAL, else 00.
  - PCsrc: 1 for JAL, else 0.
- TRAP: illegal=1, all strobes and reqs 0, retired frozen. Only reset exits.
- Strobes (IRwrite, RegWrite, PCwrite) are single-cycle pulses. All outputs are registered-state decodes with no combinational path from imem_ack/dmem_ack to strobes other than the ack-cycle pulses defined above.
- Latency: R/I/LUI/JAL = fetch + 3 cycles; branch = fetch + 2; SW = fetch + 2 + mem wait; LW = fetch + 3 + mem wait.
- retired wraps all-ones -> 0 without flag.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), imem_ack 1 cycle after req -> DECODE, EXEC with ALUctrl=0000 ALUsrc=0; WB RegWrite=1 ResultSrc=00 PCwrite=1 PCsrc=0; retired=1.
- SRAI (0x4020D093) then SUB (0x402081B3) -> ALUctrl 0111 ALUsrc=1, then 0001 ALUsrc=0; retired=2.
- BEQ (0x00208463) with EQ=1, then BNE (0x00209463) with EQ=1 -> PCsrc=1 then PCsrc=0; RegWrite never asserted.
- LW (0x0000A183), dmem_ack delayed 3 cycles -> dmem_req high exactly 4 cycles, dmem_we=0, then WB RegWrite=1 ResultSrc=01. SW (0x0020A023) -> dmem_we=1, no RegWrite.
- Opcode 0x0000007F, or R-type funct7=0000001 -> illegal=1 from cycle after DECODE; imem_req stays 0 for 20 cycles; retired unchanged.
- rst_n low during MEM with dmem_req=1 -> dmem_req=0 asynchronously, retired=0; after release imem_req=1 next cycle, JAL (0x008000EF) -> WB ResultSrc=10 PCsrc=1.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch, decode, exec, mem, writeback, with a sticky trap on illegal opcodes.
// Strobes are decoded from the registered state, except IRwrite and the SW-completion PCwrite, which pulse in the ack cycle.
module multi_cycle_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  output logic                 imem_req,
  input  logic                 imem_ack,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ack,
  input  logic                 EQ,
  output logic [3:0]           ALUctrl,
  output logic                 ALUsrc,
  output logic [2:0]           ImmSrc,
  output logic                 IRwrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic                 PCwrite,
  output logic                 PCsrc,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  typedef enum logic [2:0] {C_R, C_I, C_LW, C_SW, C_BR, C_LUI, C_JAL} cls_t;

  state_t      state, state_nxt;
  cls_t        cls_q, dec_cls;
  logic        started;
  logic [6:0]  ir_op, ir_f7;
  logic [2:0]  ir_f3;
  logic [3:0]  ctrl_q, dec_ctrl;
  logic        src_q, dec_src, bne_q;
  logic [2:0]  imm_q, dec_imm;
  logic        dec_illegal, retire;
  logic        unused_instr;

  // Register and immediate fields are consumed by the datapath, not here.
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? 4'b0001 : 4'b0000;
      3'b001:  alu_op = 4'b0010;
      3'b010:  alu_op = 4'b0011;
      3'b011:  alu_op = 4'b0100;
      3'b100:  alu_op = 4'b0101;
      3'b101:  alu_op = alt ? 4'b0111 : 4'b0110;
      3'b110:  alu_op = 4'b1000;
      default: alu_op = 4'b1001;
    endcase
  endfunction

  always_comb begin
    dec_cls     = C_R;
    dec_ctrl    = 4'b0000;
    dec_src     = 1'b0;
    dec_imm     = 3'b000;
    dec_illegal = 1'b0;
    case (ir_op)
      7'b0110011: begin
        dec_ctrl    = alu_op(ir_f3, ir_f7[5]);
        dec_illegal = !((ir_f7 == 7'h00) ||
                        ((ir_f7 == 7'h20) && ((ir_f3 == 3'b000) || (ir_f3 == 3'b101))));
      end
      7'b0010011: begin
        dec_cls     = C_I;
        dec_ctrl    = alu_op(ir_f3, (ir_f3 == 3'b101) && ir_f7[5]);
        dec_src     = 1'b1;
        dec_illegal = ((ir_f3 == 3'b001) && (ir_f7 != 7'h00)) ||
                      ((ir_f3 == 3'b101) && (ir_f7 != 7'h00) && (ir_f7 != 7'h20));
      end
      7'b0000011: begin
        dec_cls     = C_LW;
        dec_src     = 1'b1;
        dec_illegal = (ir_f3 != 3'b010);
      end
      7'b0100011: begin
        dec_cls     = C_SW;
        dec_src     = 1'b1;
        dec_imm     = 3'b001;
        dec_illegal = (ir_f3 != 3'b010);
      end
      7'b1100011: begin
        dec_cls     = C_BR;
        dec_ctrl    = 4'b0001;
        dec_imm     = 3'b010;
        dec_illegal = (ir_f3[2:1] != 2'b00);
      end
      7'b0110111: begin
        dec_cls  = C_LUI;
        dec_ctrl = 4'b1111;
        dec_src  = 1'b1;
        dec_imm  = 3'b011;
      end
      7'b1101111: begin
        dec_cls = C_JAL;
        dec_imm = 3'b100;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // started keeps the fetch request low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      started <= 1'b0;
      ir_op   <= '0;
      ir_f3   <= '0;
      ir_f7   <= '0;
      cls_q   <= C_R;
      ctrl_q  <= '0;
      src_q   <= 1'b0;
      imm_q   <= '0;
      bne_q   <= 1'b0;
      retired <= '0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      if (IRwrite) begin
        ir_op <= instr[6:0];
        ir_f3 <= instr[14:12];
        ir_f7 <= instr[31:25];
      end
      if (state == DECODE) begin
        cls_q  <= dec_cls;
        ctrl_q <= dec_ctrl;
        src_q  <= dec_src;
        imm_q  <= dec_imm;
        bne_q  <= ir_f3[0];
      end
      if (retire) retired <= retired + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    IRwrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    PCwrite   = 1'b0;
    PCsrc     = 1'b0;
    illegal   = 1'b0;
    retire    = 1'b0;
    ALUctrl   = 4'b0000;
    ALUsrc    = 1'b0;
    ImmSrc    = 3'b000;
    if ((state == EXEC) || (state == MEM) || (state == WB)) begin
      ALUctrl = ctrl_q;
      ALUsrc  = src_q;
      ImmSrc  = imm_q;
    end
    case (state)
      FETCH: begin
        imem_req = started;
        if (started && imem_ack) begin
          IRwrite   = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: state_nxt = dec_illegal ? TRAP : EXEC;
      EXEC: begin
        if (cls_q == C_BR) begin
          PCwrite   = 1'b1;
          PCsrc     = bne_q ? ~EQ : EQ;
          retire    = 1'b1;
          state_nxt = FETCH;
        end else if ((cls_q == C_LW) || (cls_q == C_SW)) begin
          state_nxt = MEM;
        end else begin
          state_nxt = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_SW);
        if (dmem_ack) begin
          if (cls_q == C_SW) begin
            PCwrite   = 1'b1;
            retire    = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = WB;
          end
        end
      end
      WB: begin
        RegWrite  = 1'b1;
        PCwrite   = 1'b1;
        retire    = 1'b1;
        ResultSrc = (cls_q == C_LW) ? 2'b01 : ((cls_q == C_JAL) ? 2'b10 : 2'b00);
        PCsrc     = (cls_q == C_JAL);
        state_nxt = FETCH;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: inputs change on the falling edge, outputs are sampled 1 time unit later.
module tb_multi_cycle_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, EQ = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ALUsrc, IRwrite, RegWrite, PCwrite, PCsrc, illegal;
  logic [3:0]  ALUctrl;
  logic [2:0]  ImmSrc;
  logic [1:0]  ResultSrc;
  logic [31:0] retired;

  int   pass_cnt = 0, total_cnt = 0;
  logic req_at_ack, irw_at_ack;

  multi_cycle_ctrl #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .EQ(EQ),
    .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc), .IRwrite(IRwrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .PCwrite(PCwrite), .PCsrc(PCsrc),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  task step();
    @(negedge clk);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
  endtask

  task fetch(input logic [31:0] w, input int dly);
    repeat (dly) step();
    @(negedge clk);
    instr = w;
    imem_ack = 1'b1;
    #1;
    req_at_ack = imem_req;
    irw_at_ack = IRwrite;
  endtask

  task test_reset();
    #2;
    total_cnt++; if ({imem_req, dmem_req, dmem_we, IRwrite, RegWrite, PCwrite, PCsrc, illegal} !== 8'h00) $display("FAIL reset_strobes got %b want 00000000", {imem_req, dmem_req, dmem_we, IRwrite, RegWrite, PCwrite, PCsrc, illegal}); else pass_cnt++;
    total_cnt++; if ({ALUctrl, ALUsrc, ImmSrc, ResultSrc} !== 10'h000) $display("FAIL reset_ctrl got %b want 0", {ALUctrl, ALUsrc, ImmSrc, ResultSrc}); else pass_cnt++;
    total_cnt++; if (retired !== 32'd0) $display("FAIL reset_retired got %0d want 0", retired); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL release_req got %b want 0", imem_req); else pass_cnt++;
  endtask

  task test_add();
    fetch(32'h002081B3, 1);
    total_cnt++; if ({req_at_ack, irw_at_ack} !== 2'b11) $display("FAIL add_fetch got %b want 11", {req_at_ack, irw_at_ack}); else pass_cnt++;
    step();
    total_cnt++; if ({IRwrite, imem_req, RegWrite} !== 3'b000) $display("FAIL add_decode got %b want 000", {IRwrite, imem_req, RegWrite}); else pass_cnt++;
    step();
    total_cnt++; if ({ALUctrl, ALUsrc, PCwrite} !== 6'b0000_0_0) $display("FAIL add_exec got %b want 000000", {ALUctrl, ALUsrc, PCwrite}); else pass_cnt++;
    step();
    total_cnt++; if ({RegWrite, ResultSrc, PCwrite, PCsrc} !== 5'b1_00_1_0) $display("FAIL add_wb got %b want 10010", {RegWrite, ResultSrc, PCwrite, PCsrc}); else pass_cnt++;
    step();
    total_cnt++; if (retired !== 32'd1) $display("FAIL add_retired got %0d want 1", retired); else pass_cnt++;
    total_cnt++; if ({imem_req, RegWrite, PCwrite} !== 3'b100) $display("FAIL add_refetch got %b want 100", {imem_req, RegWrite, PCwrite}); else pass_cnt++;
  endtask

  task test_srai_sub();
    fetch(32'h4020D093, 0);
    step(); step();
    total_cnt++; if ({ALUctrl, ALUsrc, ImmSrc} !== 8'b0111_1_000) $display("FAIL srai_exec got %b want 01111000", {ALUctrl, ALUsrc, ImmSrc}); else pass_cnt++;
    step();
    total_cnt++; if ({ALUctrl, ALUsrc, RegWrite} !== 6'b0111_1_1) $display("FAIL srai_wb_hold got %b want 011111", {ALUctrl, ALUsrc, RegWrite}); else pass_cnt++;
    step();
    fetch(32'h402081B3, 0);
    step(); step();
    total_cnt++; if ({ALUctrl, ALUsrc} !== 5'b0001_0) $display("FAIL sub_exec got %b want 00010", {ALUctrl, ALUsrc}); else pass_cnt++;
    step(); step();
    total_cnt++; if (retired !== 32'd3) $display("FAIL srai_sub_retired got %0d want 3", retired); else pass_cnt++;
  endtask

  task test_branch();
    EQ = 1'b1;
    fetch(32'h00208463, 0);
    step();
    total_cnt++; if ({RegWrite, PCwrite} !== 2'b00) $display("FAIL beq_decode got %b want 00", {RegWrite, PCwrite}); else pass_cnt++;
    step();
    total_cnt++; if ({ALUctrl, ALUsrc, ImmSrc} !== 8'b0001_0_010) $display("FAIL beq_ctrl got %b want 00010010", {ALUctrl, ALUsrc, ImmSrc}); else pass_cnt++;
    total_cnt++; if ({PCwrite, PCsrc, RegWrite} !== 3'b110) $display("FAIL beq_taken got %b want 110", {PCwrite, PCsrc, RegWrite}); else pass_cnt++;
    step();
    total_cnt++; if ({PCwrite, imem_req, retired} !== {2'b01, 32'd4}) $display("FAIL beq_after got %b/%0d want 01/4", {PCwrite, imem_req}, retired); else pass_cnt++;
    fetch(32'h00209463, 0);
    step(); step();
    total_cnt++; if ({PCwrite, PCsrc, RegWrite} !== 3'b100) $display("FAIL bne_not_taken got %b want 100", {PCwrite, PCsrc, RegWrite}); else pass_cnt++;
    step();
    total_cnt++; if (retired !== 32'd5) $display("FAIL bne_retired got %0d want 5", retired); else pass_cnt++;
    EQ = 1'b0;
  endtask

  task test_load_store();
    int req_cnt;
    logic we_any;
    req_cnt = 0;
    we_any = 1'b0;
    fetch(32'h0000A183, 0);
    step(); step();
    total_cnt++; if ({ALUctrl, ALUsrc, ImmSrc, dmem_req} !== 9'b0000_1_000_0) $display("FAIL lw_exec got %b want 000010000", {ALUctrl, ALUsrc, ImmSrc, dmem_req}); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (dmem_req === 1'b1) req_cnt++;
      if (dmem_we !== 1'b0) we_any = 1'b1;
      if (i == 3) dmem_ack = 1'b1;
    end
    step();
    total_cnt++; if (req_cnt !== 4 || dmem_req !== 1'b0) $display("FAIL lw_req_cycles got %0d (now %b) want 4 (now 0)", req_cnt, dmem_req); else pass_cnt++;
    total_cnt++; if (we_any !== 1'b0) $display("FAIL lw_we got %b want 0", we_any); else pass_cnt++;
    total_cnt++; if ({RegWrite, ResultSrc, PCwrite, PCsrc} !== 5'b1_01_1_0) $display("FAIL lw_wb got %b want 10110", {RegWrite, ResultSrc, PCwrite, PCsrc}); else pass_cnt++;
    step();
    fetch(32'h0020A023, 0);
    step(); step();
    total_cnt++; if ({ALUsrc, ImmSrc} !== 4'b1_001) $display("FAIL sw_exec got %b want 1001", {ALUsrc, ImmSrc}); else pass_cnt++;
    step();
    total_cnt++; if ({dmem_req, dmem_we, PCwrite} !== 3'b110) $display("FAIL sw_mem got %b want 110", {dmem_req, dmem_we, PCwrite}); else pass_cnt++;
    dmem_ack = 1'b1;
    #1;
    total_cnt++; if ({PCwrite, PCsrc, RegWrite} !== 3'b100) $display("FAIL sw_ack got %b want 100", {PCwrite, PCsrc, RegWrite}); else pass_cnt++;
    step();
    total_cnt++; if ({dmem_req, RegWrite, retired} !== {2'b00, 32'd7}) $display("FAIL sw_done got %b/%0d want 00/7", {dmem_req, RegWrite}, retired); else pass_cnt++;
  endtask

  task test_illegal();
    int req_cnt, strobe_cnt;
    req_cnt = 0;
    strobe_cnt = 0;
    fetch(32'h0000007F, 0);
    step();
    total_cnt++; if (illegal !== 1'b0) $display("FAIL ill_decode got %b want 0", illegal); else pass_cnt++;
    step();
    total_cnt++; if (illegal !== 1'b1) $display("FAIL ill_trap got %b want 1", illegal); else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      #1;
      if (imem_req !== 1'b0) req_cnt++;
      if ({IRwrite, RegWrite, PCwrite, dmem_req, illegal} !== 5'b00001) strobe_cnt++;
      step();
    end
    total_cnt++; if (req_cnt !== 0) $display("FAIL ill_req_cycles got %0d want 0", req_cnt); else pass_cnt++;
    total_cnt++; if (strobe_cnt !== 0) $display("FAIL ill_strobes got %0d want 0", strobe_cnt); else pass_cnt++;
    total_cnt++; if (retired !== 32'd7) $display("FAIL ill_retired got %0d want 7", retired); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({illegal, retired} !== 33'd0) $display("FAIL ill_reset got %b/%0d want 0/0", illegal, retired); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    fetch(32'h022081B3, 0);
    step(); step();
    total_cnt++; if ({illegal, imem_req} !== 2'b10) $display("FAIL ill_funct7 got %b want 10", {illegal, imem_req}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task test_reset_mid();
    fetch(32'h002081B3, 0);
    step(); step(); step(); step();
    fetch(32'h0000A183, 0);
    step(); step(); step();
    total_cnt++; if ({dmem_req, retired} !== {1'b1, 32'd1}) $display("FAIL mid_mem got %b/%0d want 1/1", dmem_req, retired); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({dmem_req, retired} !== 33'd0) $display("FAIL mid_async got %b/%0d want 0/0", dmem_req, retired); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_cnt++; if ({imem_req, PCwrite, RegWrite, dmem_req} !== 4'b0000) $display("FAIL mid_release got %b want 0000", {imem_req, PCwrite, RegWrite, dmem_req}); else pass_cnt++;
    fetch(32'h008000EF, 0);
    total_cnt++; if ({req_at_ack, irw_at_ack} !== 2'b11) $display("FAIL jal_fetch got %b want 11", {req_at_ack, irw_at_ack}); else pass_cnt++;
    step(); step();
    total_cnt++; if ({ALUctrl, ImmSrc} !== 7'b0000_100) $display("FAIL jal_exec got %b want 0000100", {ALUctrl, ImmSrc}); else pass_cnt++;
    step();
    total_cnt++; if ({RegWrite, ResultSrc, PCwrite, PCsrc} !== 5'b1_10_1_1) $display("FAIL jal_wb got %b want 11011", {RegWrite, ResultSrc, PCwrite, PCsrc}); else pass_cnt++;
    step();
    total_cnt++; if (retired !== 32'd1) $display("FAIL jal_retired got %0d want 1", retired); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_srai_sub();
    test_branch();
    test_load_store();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
